mem_port_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer for the 5-stage pipelined CPU. It shares one unified, variable-latency memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage). It grants one access at a time, holds the request to memory until it is acknowledged, and returns a one-cycle ready pulse with read data. The pipeline uses that pulse as its stall-release condition.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_priority.sv | 22 ++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_TIMEOUT      = 64;
  localparam int DEF_D_STREAK_MAX = 2;

endpackage

// File: rtl/arb_priority.sv
// Grant logic for the shared memory port: data wins by default, but a waiting
// fetch wins once the data streak has saturated.
module arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STREAK_W     = 2,
  parameter int D_STREAK_MAX = DEF_D_STREAK_MAX
) (
  input  logic                i_req_i,
  input  logic                d_req_i,
  input  logic [STREAK_W-1:0] d_streak_i,
  output logic                grant_o,
  output owner_e              owner_o
);

  logic starved;

  assign starved = i_req_i && (d_streak_i >= STREAK_W'(D_STREAK_MAX));
  assign grant_o = i_req_i || d_req_i;
  assign owner_o = (d_req_i && !starved) ? OWN_D : OWN_I;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between the IF and MEM requesters,
// one access at a time, returning a registered one-cycle ready pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int D_STREAK_MAX = DEF_D_STREAK_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int STREAK_W = $clog2(D_STREAK_MAX + 1);
  localparam int TO_W     = $clog2(TIMEOUT);
  localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(D_STREAK_MAX);
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT - 1);

  state_e              state_q;
  owner_e              owner_q;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TO_W-1:0]     to_cnt_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                i_ready_q, d_ready_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;
  logic                busy_q, err_q;

  logic                grant;
  owner_e              grant_owner;
  logic [DATA_W-1:0]   resp_data;

  arb_priority #(
    .STREAK_W    (STREAK_W),
    .D_STREAK_MAX(D_STREAK_MAX)
  ) u_arb (
    .i_req_i   (i_req),
    .d_req_i   (d_req),
    .d_streak_i(streak_q),
    .grant_o   (grant),
    .owner_o   (grant_owner)
  );

  // Streak counts data grants that overtook a waiting fetch; saturates at the limit.
  always_comb begin
    streak_d = streak_q;
    if (grant_owner == OWN_I || !i_req) begin
      streak_d = '0;
    end else if (streak_q != STREAK_SAT) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Stores and timeouts return zero data to the owner.
  assign resp_data = (mem_ack && !mem_we_q) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      streak_q    <= '0;
      to_cnt_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q   <= grant_owner;
            streak_q  <= streak_d;
            to_cnt_q  <= '0;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= BUSY;
            if (grant_owner == OWN_D) begin
              mem_addr_q  <= d_addr;
              mem_we_q    <= d_we;
              mem_wdata_q <= d_wdata;
            end else begin
              mem_addr_q  <= i_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack || to_cnt_q == TO_LAST) begin
            if (!mem_ack) begin
              err_q <= 1'b1;
            end
            if (owner_q == OWN_D) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= resp_data;
            end else begin
              i_ready_q <= 1'b1;
              i_rdata_q <= resp_data;
            end
            mem_req_q <= 1'b0;
            to_cnt_q  <= '0;
            state_q   <= RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// reset/late-ack sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int TIMEOUT      = 8;
  localparam int D_STREAK_MAX = 2;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  typedef struct {
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    int          ackCycle;
    logic [31:0] memRdata;
    logic        expOwnerD;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  logic              clk;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              err;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[12];

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT     (TIMEOUT),
    .D_STREAK_MAX(D_STREAK_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ready  (i_ready),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    checkOutput({tag, "_i_ready"}, 32'(i_ready), 32'h0);
    checkOutput({tag, "_d_ready"}, 32'(d_ready), 32'h0);
    checkOutput({tag, "_i_rdata"}, i_rdata, 32'h0);
    checkOutput({tag, "_d_rdata"}, d_rdata, 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // One full access, entered and left in an idle cycle.
  task automatic applyStimulus(input vec_t v);
    int          readyCycle;
    logic [31:0] expAddr;
    logic        expWe;
    i_req     = v.iReq;
    i_addr    = v.iAddr;
    d_req     = v.dReq;
    d_we      = v.dWe;
    d_addr    = v.dAddr;
    d_wdata   = v.dWdata;
    mem_ack   = 1'b0;
    mem_rdata = GARBAGE;
    expAddr   = v.expOwnerD ? v.dAddr : v.iAddr;
    expWe     = v.expOwnerD ? v.dWe : 1'b0;
    readyCycle = (v.ackCycle >= 1 && v.ackCycle <= TIMEOUT) ? v.ackCycle + 1 : TIMEOUT + 1;
    tick();
    for (int c = 1; c < readyCycle; c++) begin
      checkOutput("busy_mem_req", 32'(mem_req), 32'h1);
      checkOutput("busy_flag", 32'(busy), 32'h1);
      checkOutput("busy_mem_addr", mem_addr, expAddr);
      checkOutput("busy_mem_we", 32'(mem_we), 32'(expWe));
      if (expWe) checkOutput("busy_mem_wdata", mem_wdata, v.dWdata);
      checkOutput("busy_i_ready", 32'(i_ready), 32'h0);
      checkOutput("busy_d_ready", 32'(d_ready), 32'h0);
      if (c == v.ackCycle) begin
        mem_ack   = 1'b1;
        mem_rdata = v.memRdata;
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = GARBAGE;
    end
    checkOutput("resp_i_ready", 32'(i_ready), 32'(!v.expOwnerD));
    checkOutput("resp_d_ready", 32'(d_ready), 32'(v.expOwnerD));
    checkOutput("resp_data", v.expOwnerD ? d_rdata : i_rdata, v.expData);
    checkOutput("resp_err", 32'(err), 32'(v.expErr));
    checkOutput("resp_mem_req", 32'(mem_req), 32'h0);
    checkOutput("resp_busy", 32'(busy), 32'h1);
    if (v.expOwnerD) d_req = 1'b0;
    else i_req = 1'b0;
    if (readyCycle == TIMEOUT + 1) mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("idle_i_ready", 32'(i_ready), 32'h0);
    checkOutput("idle_d_ready", 32'(d_ready), 32'h0);
    checkOutput("idle_err", 32'(err), 32'(v.expErr));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        v;
    logic        iPend, dPend, rDWe, ownerD, timedOut, errModel;
    logic [31:0] rIAddr, rDAddr, rDWdata;
    int          dStreakModel;

    //            iReq  iAddr         dReq  dWe   dAddr         dWdata        ack memRdata      ownD  expData       err
    vecs[0]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,        32'h0,        1, 32'h0050_0093, 1'b0, 32'h0050_0093, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0080, 32'h0,        1, 32'h1111_1111, 1'b1, 32'h1111_1111, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0084, 32'hCAFE_F00D, 1, 32'h2222_2222, 1'b1, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0088, 32'h0,        1, 32'h3333_3333, 1'b0, 32'h3333_3333, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0088, 32'h0,        1, 32'h4444_4444, 1'b1, 32'h4444_4444, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0044, 1'b1, 1'b1, 32'h0000_008C, 32'h0BAD_F00D, 1, 32'h5555_5555, 1'b1, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0090, 32'h0,        1, 32'h6666_6666, 1'b0, 32'h6666_6666, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0048, 1'b1, 1'b0, 32'h0000_0090, 32'h0,        2, 32'h7777_7777, 1'b1, 32'h7777_7777, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0048, 1'b1, 1'b0, 32'h0000_0094, 32'h0,        6, 32'h8888_8888, 1'b1, 32'h8888_8888, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0048, 1'b1, 1'b0, 32'h0000_0098, 32'h0,        8, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0048, 1'b1, 1'b0, 32'h0000_0098, 32'h0,        0, 32'hBBBB_BBBB, 1'b1, 32'h0,         1'b1};
    vecs[11] = '{1'b1, 32'h0000_004C, 1'b0, 1'b0, 32'h0,        32'h0,        1, 32'h0000_1234, 1'b0, 32'h0000_1234, 1'b1};

    reset     = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #2 reset = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(posedge clk);
    #4 reset = 1'b1;
    tick();

    for (int n = 0; n < 11; n++) applyStimulus(vecs[n]);

    // Late ack after the timeout must not start or complete anything.
    mem_ack   = 1'b1;
    mem_rdata = GARBAGE;
    repeat (2) begin
      tick();
      checkOutput("late_ack_busy", 32'(busy), 32'h0);
      checkOutput("late_ack_mem_req", 32'(mem_req), 32'h0);
      checkOutput("late_ack_ready", 32'({i_ready, d_ready}), 32'h0);
      checkOutput("late_ack_err", 32'(err), 32'h1);
    end
    mem_ack = 1'b0;
    applyStimulus(vecs[11]);

    // Reset in the middle of a data access, then the held request completes.
    v = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 3, 32'hFEED_FACE, 1'b1, 32'hFEED_FACE, 1'b0};
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_00C0;
    tick();
    checkOutput("prereset_mem_req", 32'(mem_req), 32'h1);
    tick();
    #2 reset = 1'b0;
    #1 checkAllZero("midreset");
    @(posedge clk);
    #1;
    checkOutput("midreset_no_ready", 32'({i_ready, d_ready}), 32'h0);
    checkOutput("midreset_mem_req", 32'(mem_req), 32'h0);
    #3 reset = 1'b1;
    applyStimulus(v);

    // Randomized traffic against a transaction-level model.
    iPend        = 1'b0;
    dPend        = 1'b0;
    rDWe         = 1'b0;
    rIAddr       = '0;
    rDAddr       = '0;
    rDWdata      = '0;
    dStreakModel = 0;
    errModel     = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (!iPend && $urandom_range(0, 2) != 0) begin
        iPend  = 1'b1;
        rIAddr = 32'h0000_1000 + 32'($urandom_range(0, 63)) * 4;
      end
      if (!dPend && $urandom_range(0, 2) != 0) begin
        dPend   = 1'b1;
        rDWe    = 1'($urandom_range(0, 1));
        rDAddr  = 32'h0000_2000 + 32'($urandom_range(0, 63)) * 4;
        rDWdata = $urandom;
      end
      if (!iPend && !dPend) begin
        i_req   = 1'b0;
        d_req   = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        tick();
        mem_ack = 1'b0;
        checkOutput("rand_idle_busy", 32'(busy), 32'h0);
        checkOutput("rand_idle_mem_req", 32'(mem_req), 32'h0);
      end else begin
        ownerD   = dPend && !(iPend && dStreakModel >= D_STREAK_MAX);
        v.iReq     = iPend;
        v.iAddr    = rIAddr;
        v.dReq     = dPend;
        v.dWe      = rDWe;
        v.dAddr    = rDAddr;
        v.dWdata   = rDWdata;
        v.ackCycle = $urandom_range(1, TIMEOUT + 2);
        v.memRdata = $urandom;
        timedOut   = v.ackCycle > TIMEOUT;
        if (timedOut) errModel = 1'b1;
        v.expOwnerD = ownerD;
        v.expData   = (timedOut || (ownerD && rDWe)) ? 32'h0 : v.memRdata;
        v.expErr    = errModel;
        dStreakModel = (ownerD && iPend) ? dStreakModel + 1 : 0;
        applyStimulus(v);
        if (ownerD) dPend = 1'b0;
        else iPend = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
